// File: rtl/rf_2r1w_if.sv
// rf_2r1w_if: read/write bus between a core (master) and rf_2r1w (slave).
//   ready           : register file accepting reads/writes
//   we/waddr/wdata  : write port
//   re0/raddr0      : read port 0 request, rdata0 registered result
//   re1/raddr1      : read port 1 request, rdata1 registered result
interface rf_2r1w_if #(
  parameter int WORD_SIZE = 32,
  parameter int AW        = 5
);
  logic                 ready;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [WORD_SIZE-1:0] wdata;
  logic                 re0;
  logic [AW-1:0]        raddr0;
  logic [WORD_SIZE-1:0] rdata0;
  logic                 re1;
  logic [AW-1:0]        raddr1;
  logic [WORD_SIZE-1:0] rdata1;

  modport master (
    input  ready, rdata0, rdata1,
    output we, waddr, wdata, re0, raddr0, re1, raddr1
  );

  modport slave (
    output ready, rdata0, rdata1,
    input  we, waddr, wdata, re0, raddr0, re1, raddr1
  );
endinterface

// File: rtl/rf_2r1w.sv
// rf_2r1w: two-read/one-write register file with registered reads,
// write-first bypass, optional hardwired-zero entry 0 and an optional
// post-reset clear sequence.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rf_2r1w_if slave (ready, write port, two read ports)
module rf_2r1w #(
  parameter int WORD_SIZE      = 32,
  parameter int REG_COUNT      = 32,
  parameter int ZERO_REG       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       rst,
  rf_2r1w_if.slave   bus
);
  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  localparam logic [AW:0]   RC_EXT    = (AW+1)'(REG_COUNT);
  localparam logic [AW-1:0] LAST      = AW'(REG_COUNT - 1);
  localparam bit            ZR        = (ZERO_REG != 0);
  localparam state_t        RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  logic [WORD_SIZE-1:0] mem_q [REG_COUNT];

  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [WORD_SIZE-1:0] rdata0_q, rdata0_d;
  logic [WORD_SIZE-1:0] rdata1_q, rdata1_d;

  logic                 mem_we;
  logic [AW-1:0]        mem_wa;
  logic [WORD_SIZE-1:0] mem_wd;
  logic                 wr_eff;

  // Address is backed by a real, writable/readable entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < RC_EXT) && !(ZR && (a == '0));
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mem_we   = 1'b0;
    mem_wa   = bus.waddr;
    mem_wd   = bus.wdata;
    wr_eff   = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
        wr_eff  = bus.we && addr_ok(bus.waddr);
        mem_we  = wr_eff;

        if (bus.re0) begin
          if (!addr_ok(bus.raddr0))
            rdata0_d = '0;
          else if (wr_eff && (bus.waddr == bus.raddr0))
            rdata0_d = bus.wdata;
          else
            rdata0_d = mem_q[bus.raddr0];
        end

        if (bus.re1) begin
          if (!addr_ok(bus.raddr1))
            rdata1_d = '0;
          else if (wr_eff && (bus.waddr == bus.raddr1))
            rdata1_d = bus.wdata;
          else
            rdata1_d = mem_q[bus.raddr1];
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Storage has no reset; a write coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      mem_q[mem_wa] <= mem_wd;
  end

  assign bus.ready  = ready_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
endmodule
